// File: rtl/rca_grid_lsq_if.sv
// Memory-side request/response port of the RCA grid load/store queue.
// master = queue side, slave = memory/load-store-unit side.
interface rca_grid_lsq_if #(
    parameter int XLEN = 32
) ();
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic [XLEN-1:0] mem_req_data;
    logic [2:0]      mem_req_fn3;
    logic            mem_req_load;
    logic            mem_req_store;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_fn3,
               mem_req_load, mem_req_store,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_fn3,
               mem_req_load, mem_req_store,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/rca_grid_lsq.sv
// Load/store queue behind the RCA PR grid: gathers per-row requests into a FIFO and
// serialises them onto one memory port. Optional RCA_LSQ_STATS_EN adds saturating counters.
module rca_grid_lsq #(
    parameter int XLEN          = 32,
    parameter int GRID_NUM_ROWS = 2,
    parameter int LSQ_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [GRID_NUM_ROWS*XLEN-1:0] row_addr,
    input  logic [GRID_NUM_ROWS*XLEN-1:0] row_data,
    input  logic [GRID_NUM_ROWS*3-1:0]    row_fn3,
    input  logic [GRID_NUM_ROWS-1:0]      row_load,
    input  logic [GRID_NUM_ROWS-1:0]      row_store,
    input  logic [GRID_NUM_ROWS-1:0]      row_new_request,
    output logic                          lsq_full,
    output logic [XLEN-1:0]               load_data,
    output logic [GRID_NUM_ROWS-1:0]      load_complete,
    rca_grid_lsq_if.master                mem
`ifdef RCA_LSQ_STATS_EN
    ,
    output logic [31:0]                   stat_loads,
    output logic [31:0]                   stat_stores,
    output logic [31:0]                   stat_full_cycles
`endif
);
    localparam int PTR_W = $clog2(LSQ_DEPTH);
    localparam int CNT_W = $clog2(LSQ_DEPTH) + 1;
    localparam int ROW_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    logic [ROW_W-1:0] fifo_row   [LSQ_DEPTH];
    logic [XLEN-1:0]  fifo_addr  [LSQ_DEPTH];
    logic [XLEN-1:0]  fifo_data  [LSQ_DEPTH];
    logic [2:0]       fifo_fn3   [LSQ_DEPTH];
    logic             fifo_load  [LSQ_DEPTH];
    logic             fifo_store [LSQ_DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    state_t           state_reg, state_next;
    logic             discard_reg, discard_next;
    logic [ROW_W-1:0] resp_row_reg, resp_row_next;
    logic [XLEN-1:0]  load_data_reg, load_data_next;
    logic [GRID_NUM_ROWS-1:0] load_complete_reg, load_complete_next;

    logic [GRID_NUM_ROWS-1:0] enq_ok;
    logic [CNT_W-1:0]         enq_off [GRID_NUM_ROWS];
    logic [PTR_W-1:0]         wr_idx  [GRID_NUM_ROWS];
    logic [CNT_W-1:0]         enq_total;
    logic                     pop;
    logic                     head_load;
    logic [ROW_W-1:0]         head_row;

    assign lsq_full = (count_reg > CNT_W'(LSQ_DEPTH - GRID_NUM_ROWS));

    // Malformed requests (both/neither kind) and anything arriving while full are dropped.
    generate
        for (genvar gi = 0; gi < GRID_NUM_ROWS; gi++) begin : g_enq
            assign enq_ok[gi] = row_new_request[gi] & (row_load[gi] ^ row_store[gi])
                              & ~lsq_full & ~flush;
            assign wr_idx[gi] = wr_ptr_reg + enq_off[gi][PTR_W-1:0];
        end
    endgenerate

    // Each accepted row lands after all accepted rows with a lower index.
    always_comb begin
        enq_total = '0;
        for (int r = 0; r < GRID_NUM_ROWS; r++) begin
            enq_off[r] = enq_total;
            enq_total  = enq_total + CNT_W'(enq_ok[r]);
        end
    end

    assign head_load = fifo_load[rd_ptr_reg];
    assign head_row  = fifo_row[rd_ptr_reg];
    assign pop       = (state_reg == ISSUE) && mem.mem_req_ready;
    assign count_next = flush ? '0 : (count_reg + enq_total - CNT_W'(pop));

    always_ff @(posedge clk) begin
        for (int r = 0; r < GRID_NUM_ROWS; r++) begin
            if (enq_ok[r]) begin
                fifo_row[wr_idx[r]]   <= ROW_W'(r);
                fifo_addr[wr_idx[r]]  <= row_addr[r*XLEN +: XLEN];
                fifo_data[wr_idx[r]]  <= row_data[r*XLEN +: XLEN];
                fifo_fn3[wr_idx[r]]   <= row_fn3[r*3 +: 3];
                fifo_load[wr_idx[r]]  <= row_load[r];
                fifo_store[wr_idx[r]] <= row_store[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + enq_total[PTR_W-1:0];
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg         <= '0;
            state_reg         <= IDLE;
            discard_reg       <= 1'b0;
            resp_row_reg      <= '0;
            load_data_reg     <= '0;
            load_complete_reg <= '0;
        end else begin
            count_reg         <= count_next;
            state_reg         <= state_next;
            discard_reg       <= discard_next;
            resp_row_reg      <= resp_row_next;
            load_data_reg     <= load_data_next;
            load_complete_reg <= load_complete_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        discard_next       = discard_reg;
        resp_row_next      = resp_row_reg;
        load_data_next     = load_data_reg;
        load_complete_next = '0;
        case (state_reg)
            IDLE: begin
                if (!flush && count_reg != '0) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (pop) begin
                    if (head_load) begin
                        // A flush racing the load handshake must still absorb its response.
                        state_next    = WAIT_RESP;
                        resp_row_next = head_row;
                        discard_next  = flush;
                    end else if (!flush && count_next != '0) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            WAIT_RESP: begin
                if (mem.mem_resp_valid) begin
                    if (!discard_reg && !flush) begin
                        load_data_next     = mem.mem_resp_data;
                        load_complete_next = GRID_NUM_ROWS'(1) << resp_row_reg;
                    end
                    discard_next = 1'b0;
                    state_next   = IDLE;
                end else if (flush) begin
                    discard_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem.mem_req_valid = (state_reg == ISSUE);
    assign mem.mem_req_addr  = fifo_addr[rd_ptr_reg];
    assign mem.mem_req_data  = fifo_data[rd_ptr_reg];
    assign mem.mem_req_fn3   = fifo_fn3[rd_ptr_reg];
    assign mem.mem_req_load  = fifo_load[rd_ptr_reg];
    assign mem.mem_req_store = fifo_store[rd_ptr_reg];
    assign load_data         = load_data_reg;
    assign load_complete     = load_complete_reg;

`ifdef RCA_LSQ_STATS_EN
    logic [31:0] stat_loads_reg, stat_stores_reg, stat_full_cycles_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads_reg       <= '0;
            stat_stores_reg      <= '0;
            stat_full_cycles_reg <= '0;
        end else begin
            if (pop && head_load && stat_loads_reg != '1) begin
                stat_loads_reg <= stat_loads_reg + 32'd1;
            end
            if (pop && !head_load && stat_stores_reg != '1) begin
                stat_stores_reg <= stat_stores_reg + 32'd1;
            end
            if (lsq_full && stat_full_cycles_reg != '1) begin
                stat_full_cycles_reg <= stat_full_cycles_reg + 32'd1;
            end
        end
    end

    assign stat_loads       = stat_loads_reg;
    assign stat_stores      = stat_stores_reg;
    assign stat_full_cycles = stat_full_cycles_reg;
`endif

    a_one_kind: assert property (@(posedge clk) disable iff (rst)
        !(|(row_new_request & ~(row_load ^ row_store))));
    a_no_req_when_full: assert property (@(posedge clk) disable iff (rst)
        !(lsq_full && (|row_new_request)));
    a_resp_in_wait: assert property (@(posedge clk) disable iff (rst)
        !(mem.mem_resp_valid && state_reg != WAIT_RESP));
endmodule

// File: tb/tb_rca_grid_lsq.sv
// Self-checking bench for rca_grid_lsq: directed scenarios plus a randomized run
// scored against an in-order queue model of the request stream.
module tb_rca_grid_lsq;
    localparam int XLEN  = 32;
    localparam int ROWS  = 2;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic        ld;
        logic        st;
    } hs_t;

    typedef struct {
        logic [ROWS-1:0] lc;
        logic [31:0]     data;
    } lc_t;

    typedef struct {
        int          row;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic        ld;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [ROWS*XLEN-1:0] row_addr = '0;
    logic [ROWS*XLEN-1:0] row_data = '0;
    logic [ROWS*3-1:0]    row_fn3 = '0;
    logic [ROWS-1:0]      row_load = '0;
    logic [ROWS-1:0]      row_store = '0;
    logic [ROWS-1:0]      row_new_request = '0;
    logic                 lsq_full;
    logic [XLEN-1:0]      load_data;
    logic [ROWS-1:0]      load_complete;
`ifdef RCA_LSQ_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_full_cycles;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_load_data = '0;
    hs_t hs_q[$];
    lc_t lc_q[$];

    rca_grid_lsq_if #(.XLEN(XLEN)) mif ();

    rca_grid_lsq #(.XLEN(XLEN), .GRID_NUM_ROWS(ROWS), .LSQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .row_addr(row_addr), .row_data(row_data), .row_fn3(row_fn3),
        .row_load(row_load), .row_store(row_store), .row_new_request(row_new_request),
        .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete),
        .mem(mif)
`ifdef RCA_LSQ_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_full_cycles(stat_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Passive monitor: memory handshakes and completion pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mif.mem_req_valid === 1'b1 && mif.mem_req_ready === 1'b1)
                hs_q.push_back('{addr: mif.mem_req_addr, data: mif.mem_req_data,
                                 fn3: mif.mem_req_fn3, ld: mif.mem_req_load, st: mif.mem_req_store});
            if (load_complete !== '0)
                lc_q.push_back('{lc: load_complete, data: load_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rows();
        row_new_request = '0;
        row_load = '0;
        row_store = '0;
    endtask

    task automatic set_row(input int r, input logic ld, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f);
        row_new_request[r] = 1'b1;
        row_load[r] = ld;
        row_store[r] = !ld;
        row_addr[r*XLEN +: XLEN] = a;
        row_data[r*XLEN +: XLEN] = d;
        row_fn3[r*3 +: 3] = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        idle_rows();
        mif.mem_req_ready = 1'b0;
        mif.mem_resp_valid = 1'b0;
        mif.mem_resp_data = '0;
        tick();
        tick();
        checks++;
        if ({lsq_full, mif.mem_req_valid, load_complete, load_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got full=%b valid=%b lc=%b data=%h required all zero",
                     lsq_full, mif.mem_req_valid, load_complete, load_data);
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_load();
        hs_q.delete();
        lc_q.delete();
        mif.mem_req_ready = 1'b1;
        set_row(1, 1'b1, 32'h100, 32'h0, 3'b010);
        tick();
        idle_rows();
        checks++;
        if (mif.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_latency_n1 got valid=%b required 0", mif.mem_req_valid);
        end
        tick();
        checks++;
        if ({mif.mem_req_valid, mif.mem_req_load, mif.mem_req_store, mif.mem_req_addr}
            !== {1'b1, 1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL load_issue_n2 got valid=%b ld=%b st=%b addr=%h required 1 1 0 00000100",
                     mif.mem_req_valid, mif.mem_req_load, mif.mem_req_store, mif.mem_req_addr);
        end
        tick();
        checks++;
        if (mif.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_wait_valid got valid=%b required 0", mif.mem_req_valid);
        end
        tick();
        tick();
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data = 32'hDEADBEEF;
        tick();
        mif.mem_resp_valid = 1'b0;
        exp_load_data = 32'hDEADBEEF;
        checks++;
        if ({load_complete, load_data} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_complete_pulse got lc=%b data=%h required 10 deadbeef",
                     load_complete, load_data);
        end
        tick();
        checks++;
        if (load_complete !== 2'b00) begin
            errors++;
            $display("FAIL load_complete_one_cycle got lc=%b required 00", load_complete);
        end
        $display("test_single_load done");
    endtask

    task automatic test_dual_store();
        hs_q.delete();
        lc_q.delete();
        mif.mem_req_ready = 1'b1;
        set_row(0, 1'b0, 32'h10, 32'hA0, 3'b010);
        set_row(1, 1'b0, 32'h20, 32'hB0, 3'b001);
        tick();
        idle_rows();
        repeat (8) tick();
        checks++;
        if (hs_q.size() != 2 || lc_q.size() != 0) begin
            errors++;
            $display("FAIL dual_store_counts got hs=%0d lc=%0d required 2 0", hs_q.size(), lc_q.size());
        end else begin
            checks++;
            if ({hs_q[0].addr, hs_q[0].st, hs_q[1].addr, hs_q[1].st} !== {32'h10, 1'b1, 32'h20, 1'b1}) begin
                errors++;
                $display("FAIL dual_store_order got %h,%h required 00000010,00000020",
                         hs_q[0].addr, hs_q[1].addr);
            end
        end
        $display("test_dual_store done");
    endtask

    task automatic test_fill();
        hs_q.delete();
        mif.mem_req_ready = 1'b0;
        set_row(0, 1'b0, 32'h30, 32'h1, 3'b010);
        set_row(1, 1'b0, 32'h34, 32'h2, 3'b010);
        tick();
        idle_rows();
        checks++;
        if (lsq_full !== 1'b0) begin
            errors++;
            $display("FAIL fill_count2_full got %b required 0", lsq_full);
        end
        set_row(0, 1'b0, 32'h38, 32'h3, 3'b010);
        tick();
        idle_rows();
        checks++;
        if (lsq_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_count3_full got %b required 1", lsq_full);
        end
        tick();
        checks++;
        if ({lsq_full, mif.mem_req_valid} !== 2'b11 || hs_q.size() != 0) begin
            errors++;
            $display("FAIL fill_hold got full=%b valid=%b hs=%0d required 1 1 0",
                     lsq_full, mif.mem_req_valid, hs_q.size());
        end
        mif.mem_req_ready = 1'b1;
        tick();
        checks++;
        if (lsq_full !== 1'b0) begin
            errors++;
            $display("FAIL fill_release_full got %b required 0", lsq_full);
        end
        repeat (6) tick();
        mif.mem_req_ready = 1'b0;
        checks++;
        if (hs_q.size() != 3) begin
            errors++;
            $display("FAIL fill_drain_count got %0d required 3", hs_q.size());
        end else begin
            checks++;
            if ({hs_q[0].addr, hs_q[1].addr, hs_q[2].addr} !== {32'h30, 32'h34, 32'h38}) begin
                errors++;
                $display("FAIL fill_drain_order got %h %h %h required 30 34 38",
                         hs_q[0].addr, hs_q[1].addr, hs_q[2].addr);
            end
        end
        $display("test_fill done");
    endtask

    task automatic test_backpressure();
        logic [31:0] a, d;
        logic [2:0] f;
        a = $urandom;
        d = $urandom;
        f = 3'($urandom_range(0, 7));
        hs_q.delete();
        mif.mem_req_ready = 1'b0;
        set_row(1, 1'b0, a, d, f);
        tick();
        idle_rows();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({mif.mem_req_valid, mif.mem_req_addr, mif.mem_req_data, mif.mem_req_fn3}
                !== {1'b1, a, d, f}) begin
                errors++;
                $display("FAIL backpressure_stable cyc=%0d got v=%b a=%h d=%h f=%0d required 1 %h %h %0d",
                         i, mif.mem_req_valid, mif.mem_req_addr, mif.mem_req_data, mif.mem_req_fn3, a, d, f);
            end
            tick();
        end
        mif.mem_req_ready = 1'b1;
        tick();
        mif.mem_req_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (hs_q.size() != 1) begin
            errors++;
            $display("FAIL backpressure_count got %0d required 1", hs_q.size());
        end else begin
            checks++;
            if ({hs_q[0].addr, hs_q[0].data, hs_q[0].fn3, hs_q[0].st} !== {a, d, f, 1'b1}) begin
                errors++;
                $display("FAIL backpressure_fields got %h %h %0d required %h %h %0d",
                         hs_q[0].addr, hs_q[0].data, hs_q[0].fn3, a, d, f);
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        hs_q.delete();
        lc_q.delete();
        mif.mem_req_ready = 1'b1;
        set_row(0, 1'b1, 32'h200, 32'h0, 3'b010);
        tick();
        idle_rows();
        tick();
        tick();
        set_row(0, 1'b0, 32'h210, 32'h5, 3'b010);
        set_row(1, 1'b0, 32'h220, 32'h6, 3'b010);
        tick();
        idle_rows();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({lsq_full, mif.mem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush_cleared got full=%b valid=%b required 0 0", lsq_full, mif.mem_req_valid);
        end
        repeat (2) tick();
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data = 32'h55AA55AA;
        tick();
        mif.mem_resp_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (lc_q.size() != 0 || load_data !== exp_load_data || hs_q.size() != 1) begin
            errors++;
            $display("FAIL flush_swallow got lc=%0d data=%h hs=%0d required 0 %h 1",
                     lc_q.size(), load_data, hs_q.size(), exp_load_data);
        end
        set_row(1, 1'b1, 32'h300, 32'h0, 3'b100);
        tick();
        idle_rows();
        tick();
        checks++;
        if ({mif.mem_req_valid, mif.mem_req_addr, mif.mem_req_load} !== {1'b1, 32'h300, 1'b1}) begin
            errors++;
            $display("FAIL flush_next_issue got v=%b a=%h ld=%b required 1 00000300 1",
                     mif.mem_req_valid, mif.mem_req_addr, mif.mem_req_load);
        end
        tick();
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data = 32'h12345678;
        tick();
        mif.mem_resp_valid = 1'b0;
        exp_load_data = 32'h12345678;
        checks++;
        if ({load_complete, load_data} !== {2'b10, 32'h12345678}) begin
            errors++;
            $display("FAIL flush_later_load got lc=%b data=%h required 10 12345678", load_complete, load_data);
        end
        tick();
        $display("test_flush done");
    endtask

    task automatic test_rst_mid_issue();
        mif.mem_req_ready = 1'b0;
        set_row(0, 1'b0, 32'h400, 32'h7, 3'b010);
        tick();
        idle_rows();
        tick();
        checks++;
        if (mif.mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_issue got valid=%b required 1", mif.mem_req_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_load_data = '0;
        checks++;
        if ({lsq_full, mif.mem_req_valid, load_complete, load_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid_issue got full=%b valid=%b lc=%b data=%h required all zero",
                     lsq_full, mif.mem_req_valid, load_complete, load_data);
        end
        repeat (4) tick();
        checks++;
        if (mif.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_queue_empty got valid=%b required 0", mif.mem_req_valid);
        end
        $display("test_rst_mid_issue done");
    endtask

    task automatic test_random();
        req_t model_q[$];
        lc_t  exp_lc[$];
        int seen = 0;
        int resp_delay = -1;
        int resp_row = 0;
        logic [31:0] rdata;
        hs_q.delete();
        lc_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle_rows();
            mif.mem_resp_valid = 1'b0;
            while (seen < hs_q.size()) begin
                hs_t h;
                req_t m;
                h = hs_q[seen];
                seen++;
                checks++;
                if (model_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected_hs addr=%h required no handshake", h.addr);
                end else begin
                    m = model_q.pop_front();
                    if ({h.addr, h.data, h.fn3, h.ld, h.st} !== {m.a, m.d, m.f, m.ld, !m.ld}) begin
                        errors++;
                        $display("FAIL rand_hs got a=%h d=%h f=%0d ld=%b st=%b required a=%h d=%h f=%0d ld=%b",
                                 h.addr, h.data, h.fn3, h.ld, h.st, m.a, m.d, m.f, m.ld);
                    end
                    if (m.ld) begin
                        resp_delay = $urandom_range(0, 3);
                        resp_row = m.row;
                    end
                end
            end
            checks++;
            if (lsq_full !== (model_q.size() > DEPTH - ROWS)) begin
                errors++;
                $display("FAIL rand_full cyc=%0d got %b required %b", cyc, lsq_full, model_q.size() > DEPTH - ROWS);
            end
            if (resp_delay == 0) begin
                rdata = $urandom;
                mif.mem_resp_valid = 1'b1;
                mif.mem_resp_data = rdata;
                exp_lc.push_back('{lc: ROWS'(1) << resp_row, data: rdata});
                resp_delay = -1;
            end else if (resp_delay > 0) begin
                resp_delay--;
            end
            mif.mem_req_ready = (cyc < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc < 400 && !lsq_full) begin
                for (int r = 0; r < ROWS; r++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_t n;
                        n.row = r;
                        n.a = $urandom;
                        n.d = $urandom;
                        n.f = 3'($urandom_range(0, 7));
                        n.ld = 1'($urandom_range(0, 1));
                        set_row(r, n.ld, n.a, n.d, n.f);
                        model_q.push_back(n);
                    end
                end
            end
            tick();
        end
        idle_rows();
        mif.mem_req_ready = 1'b0;
        checks++;
        if (model_q.size() != 0 || lc_q.size() != exp_lc.size()) begin
            errors++;
            $display("FAIL rand_drain got pending=%0d lc=%0d required 0 %0d",
                     model_q.size(), lc_q.size(), exp_lc.size());
        end else begin
            for (int i = 0; i < exp_lc.size(); i++) begin
                checks++;
                if ({lc_q[i].lc, lc_q[i].data} !== {exp_lc[i].lc, exp_lc[i].data}) begin
                    errors++;
                    $display("FAIL rand_complete idx=%0d got lc=%b data=%h required lc=%b data=%h",
                             i, lc_q[i].lc, lc_q[i].data, exp_lc[i].lc, exp_lc[i].data);
                end
            end
        end
        $display("test_random done: %0d handshakes, %0d loads completed", seen, exp_lc.size());
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_dual_store();
        test_fill();
        test_backpressure();
        test_flush();
        test_rst_mid_issue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rca_grid_lsq.md
Name: rca_grid_lsq

Overview:
- Load/store queue directly downstream of the RCA PR grid.
- Collects the load/store requests issued by the leftmost PR slot of each grid row and serialises them, in arrival order, onto a single memory port.
- Returns load data to the requesting row as a one-cycle completion pulse.
- Sits between the grid's per-row LSQ signals and the core's load/store unit.

Parameters:
- XLEN, 32, data/address width.
- GRID_NUM_ROWS, 2, number of requesting rows (one requester per row).
- LSQ_DEPTH, 4, FIFO entries; must be >= GRID_NUM_ROWS and a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  PR reconfiguration flush; driven from pr_requests_incomplete
- row_addr  in  GRID_NUM_ROWS*XLEN  per-row address, row r at [r*XLEN +: XLEN]
- row_data  in  GRID_NUM_ROWS*XLEN  per-row store data
- row_fn3  in  GRID_NUM_ROWS*3  per-row funct3 (size/sign)
- row_load  in  GRID_NUM_ROWS  request is a load
- row_store  in  GRID_NUM_ROWS  request is a store
- row_new_request  in  GRID_NUM_ROWS  request strobe, one cycle per request
- lsq_full  out  1  shared back-pressure to all rows
- load_data  out  XLEN  load return data, broadcast to all rows
- load_complete  out  GRID_NUM_ROWS  one-hot, one-cycle load-done pulse
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accepted
- mem_req_addr  out  XLEN  request address
- mem_req_data  out  XLEN  store data
- mem_req_fn3  out  3  funct3
- mem_req_load  out  1  load request
- mem_req_store  out  1  store request
- mem_resp_valid  in  1  load response valid, in order, one per load
- mem_resp_data  in  XLEN  load response data

Behaviour:
- Reset values (rst high at clk edge): FIFO empty, count=0, FSM=IDLE, discard=0. lsq_full=0, mem_req_valid=0, load_complete=0, load_data=0.
- FIFO entry: {row_id, addr, data, fn3, load, store}.
- Enqueue:
  - Every row with row_new_request=1 and (row_load XOR row_store)=1 is written in the same cycle, in ascending row index order.
  - Requests with both or neither of load/store set are dropped; the block also flags this with an assertion.
- lsq_full = (count > LSQ_DEPTH - GRID_NUM_ROWS), taken combinationally from the registered count. This guarantees room for every row in any single cycle.
- A row_new_request while lsq_full=1 is illegal (assertion) and is dropped.
- count_next = count + enqueues - dequeue. Pointers wrap modulo LSQ_DEPTH.
- Memory FSM:
  - IDLE: if FIFO not empty, go to ISSUE (the head is presented the following cycle).
  - ISSUE: mem_req_valid=1 with the head fields. Fields stay stable until mem_req_ready.
    - On handshake, the head pops.
    - Store: go to IDLE, or stay in ISSUE if the FIFO is still non-empty. Stores have no completion.
    - Load: latch row_id into resp_row and go to WAIT_RESP.
  - WAIT_RESP: mem_req_valid=0, at most one outstanding load. On mem_resp_valid:
    - Register load_data = mem_resp_data.
    - Pulse load_complete[resp_row] for exactly one cycle, the cycle after the response.
    - Go to IDLE.
- Enqueue and dequeue in the same cycle when full-threshold-adjacent: count uses the net value, and lsq_full reflects it the next cycle.
- flush (synchronous, lower priority than rst):
  - FIFO cleared, count=0, no enqueue that cycle, mem_req_valid deasserted next cycle.
  - If flush occurs in ISSUE, the block returns to IDLE. A request handshaken in the flush cycle is still consumed.
  - If flush occurs in WAIT_RESP (or with a handshake on a load in the same cycle), discard=1 and the FSM stays in WAIT_RESP. The next mem_resp_valid is swallowed: no load_complete pulse, discard cleared, FSM to IDLE.
- A mem_resp_valid outside WAIT_RESP is ignored (assertion).
- Latency, empty queue to memory: request in cycle N, enqueue at the N edge, mem_req_valid in cycle N+2.

Optional Feature:
- RCA_LSQ_STATS_EN defined adds outputs stat_loads, stat_stores, stat_full_cycles (32 bits each, saturating).
  - stat_loads and stat_stores increment on each memory handshake of that type.
  - stat_full_cycles counts cycles with lsq_full=1.
  - All three clear on rst only, not on flush.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan (defaults XLEN=32, GRID_NUM_ROWS=2, LSQ_DEPTH=4):
- Single load, row 1, addr 0x100, mem_req_ready=1, response 0xDEADBEEF 3 cycles later -> mem_req_valid high in cycle N+2 with addr 0x100 and load=1; load_complete=2'b10 for one cycle with load_data=0xDEADBEEF.
- Rows 0 and 1 request stores in the same cycle (addr 0x10 and 0x20) -> two memory handshakes in order 0x10 then 0x20; no load_complete.
- Fill: 3 stores enqueued with mem_req_ready=0 -> count=3 and lsq_full=1; release ready -> lsq_full drops after the first pop (count=2).
- Back-pressure: mem_req_ready held 0 for 5 cycles -> addr/data/fn3 stable and mem_req_valid held; exactly one handshake follows.
- Flush in WAIT_RESP after row-0 load, with 2 entries queued -> FIFO empty; the next response is swallowed with no load_complete; FSM returns to IDLE; a later load completes normally.
- rst asserted mid-ISSUE -> all outputs at reset values the next cycle, count=0.
